// File: rtl/reg12_write_arbiter_pkg.sv
//==============================================================================
// Module : reg12_arb_pkg
// Brief  : Shared types, widths and helpers for the reg12 write arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package reg12_arb_pkg;

    localparam int REG_W = 12;

    // Widest supported requester count; pointers and indices are sized for it.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    // One-hot to binary index; the input is zero-extended to MAX_REQ bits.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg12_write_arbiter_if.sv
//==============================================================================
// Module : reg12_write_arbiter_if
// Brief  : Writer-side request/data bundle and register feedback/drive path.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface reg12_write_arbiter_if
    import reg12_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = REG_W
);

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [DW-1:0]      reg_q;
    logic [DW-1:0]      reg_din;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               busy;

    modport master (
        output req, wdata, lock, reg_q,
        input  reg_din, gnt, ack, busy
    );

    modport slave (
        input  req, wdata, lock, reg_q,
        output reg_din, gnt, ack, busy
    );

endinterface

`default_nettype wire

// File: rtl/reg12_write_arbiter_rr_pick.sv
//==============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin picker; scans from ptr+1 with wrap.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rr_pick
    import reg12_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  wire logic [NREQ-1:0]  req,
    input  wire logic [IDX_W-1:0] ptr,
    output logic      [NREQ-1:0]  pick,
    output logic                  valid
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_win;
    logic               w_found;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[NREQ-1:0]  = req;
        w_idx                = '0;
        w_win                = '0;
        w_found              = 1'b0;
        // Candidate k=1 is the one right after the last grant, so it ranks highest.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDX_W'((int'(ptr) + k) % NREQ);
            if (!w_found && w_req_ext[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
        pick = '0;
        for (int i = 0; i < NREQ; i++) begin
            pick[i] = w_found && (w_win == IDX_W'(i));
        end
        valid = w_found;
    end

endmodule

`default_nettype wire

// File: rtl/reg12_write_arbiter.sv
//==============================================================================
// Module : reg12_write_arbiter
// Brief  : Round-robin arbiter sharing one load-every-cycle register among
//          NREQ writers. Optional burst lock enabled by macro ARB_LOCK_EN.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module reg12_write_arbiter
    import reg12_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DW       = REG_W,
    parameter int HOLD_MAX = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    reg12_write_arbiter_if.slave  bus
);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [NREQ-1:0]     ack_q,   ack_d;
    logic [IDX_W-1:0]    ptr_q,   ptr_d;

    logic [NREQ-1:0]     w_pick;
    logic                w_pick_valid;
    logic [DW-1:0]       w_wdata [NREQ];
    logic [DW-1:0]       w_sel_data;
    logic [MAX_REQ-1:0]  w_gnt_ext;
    logic                w_hold;
    logic                w_commit;

`ifdef ARB_LOCK_EN
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                w_burst_go;
`else
    logic                w_unused_cfg;
    assign w_unused_cfg = ^{bus.lock, 32'(HOLD_MAX)};
`endif

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_slice
            assign w_wdata[i] = bus.wdata[i*DW +: DW];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .pick  (w_pick),
        .valid (w_pick_valid)
    );

    // gnt_q is one-hot while a writer is held, so an OR-mux selects its data.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                w_sel_data = w_sel_data | w_wdata[i];
            end
        end
        w_gnt_ext           = '0;
        w_gnt_ext[NREQ-1:0] = gnt_q;
    end

    assign w_hold   = |(bus.req & gnt_q);
    assign w_commit = (state_q == GRANT) && w_hold && !rst;

`ifdef ARB_LOCK_EN
    assign w_burst_go = (|(bus.lock & bus.req & gnt_q)) && (int'(cnt_q) < HOLD_MAX - 1);
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        ptr_d   = ptr_q;
`ifdef ARB_LOCK_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    gnt_d   = w_pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (w_hold) begin
                    ack_d   = gnt_q;
                    ptr_d   = onehot_idx(w_gnt_ext);
                    state_d = ACK;
                end else begin
                    // Writer withdrew before commit: no write, rotation untouched.
                    gnt_d   = '0;
                    state_d = IDLE;
`ifdef ARB_LOCK_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACK: begin
`ifdef ARB_LOCK_EN
                if (w_burst_go) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = GRANT;
                end else begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    state_d = IDLE;
                end
`else
                gnt_d   = '0;
                state_d = IDLE;
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
`ifdef ARB_LOCK_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
`ifdef ARB_LOCK_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.reg_din = w_commit ? w_sel_data : bus.reg_q;
    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.busy    = (state_q != IDLE);

endmodule

`default_nettype wire
